uart_tx_port: RTL and testbench

// Memory-mapped UART transmitter; a responder on the RAM side of the system bus, next to gpiomem.

---
 rtl/uart_tx_port.sv | 241 ++++++++++++++++++++++++
 tb/tb_uart_tx_port.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_port.sv
// uart_tx_port: memory-mapped UART transmitter on the RAM side of the bus.
// Cores write bytes to TXDATA (BASE_ADDR+0); bytes are queued in a small FIFO
// and sent on tx, LSB first. STATUS (BASE_ADDR+1) reads back
// {4'b0, overflow, busy_line, full, empty}; a write to STATUS clears overflow.
// data_out is 8'h00 outside the address window so the bus can OR it with
// gpiomem read data.
// Build option: define UART_PARITY_EN to insert an even-parity bit (8E1);
// without it the frame is 8N1.
module uart_tx_port #(
  parameter logic [8:0] BASE_ADDR    = 9'h1F0,
  parameter int         CLKS_PER_BIT = 868,
  parameter int         FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] address,
  input  logic [7:0] data_in,
  input  logic       rw,
  output logic [7:0] data_out,
  output logic       tx,
  output logic       tx_busy
);

  localparam int DATA_W = 8;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  // Even parity over one data byte: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_W-1:0] b);
    even_parity = ^b;
  endfunction

  // Address decode and write strobes
  logic hit_tx;
  logic hit_st;
  logic wr_tx_p0;
  logic wr_st_p0;
  logic wr_tx_p1;
  logic wr_st_p1;
  logic push_req;
  logic st_clr;

  assign hit_tx   = (address == BASE_ADDR);
  assign hit_st   = (address == (BASE_ADDR + 9'd1));
  assign wr_tx_p0 = rw & hit_tx;
  assign wr_st_p0 = rw & hit_st;

  // A held write acts only on its first cycle, so a long rw pulse pushes once.
  assign push_req = wr_tx_p0 & ~wr_tx_p1;
  assign st_clr   = wr_st_p0 & ~wr_st_p1;

  // ---- stage p1: previous-cycle write conditions for edge detection ----
  // Remember last cycle's write decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_tx_p1 <= 1'b0;
      wr_st_p1 <= 1'b0;
    end else begin
      wr_tx_p1 <= wr_tx_p0;
      wr_st_p1 <= wr_st_p0;
    end
  end

  // TX FIFO with one extra pointer bit so full and empty are distinguishable
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr;
  logic [PTR_W:0]    rd_ptr;
  logic              empty;
  logic              full;
  logic              pop;
  logic              push;
  logic              overflow;

  logic [2:0]        state;
  logic [CNT_W-1:0]  baud_cnt;
  logic [2:0]        bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              baud_done;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  // IDLE pops whatever was queued before this edge; a same-edge pop frees a
  // slot, so a write into a full FIFO still lands in that case.
  assign pop  = (state == S_IDLE) & ~empty;
  assign push = push_req & (~full | pop);

  // FIFO pointers; reset discards any queued bytes.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // FIFO storage; contents are meaningless while the pointers say empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= data_in;
  end

  // Sticky overflow: set when a TXDATA write is dropped, cleared by a STATUS write.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (st_clr) begin
      overflow <= 1'b0;
    end else if (push_req && !push) begin
      overflow <= 1'b1;
    end
  end

  // Frame shift register loaded on pop.
  always_ff @(posedge clk) begin
    if (pop) shreg <= mem[rd_ptr[PTR_W-1:0]];
  end

`ifdef UART_PARITY_EN
  logic par_bit;

  // Parity of the byte being sent, captured alongside it.
  always_ff @(posedge clk) begin
    if (pop) par_bit <= even_parity(mem[rd_ptr[PTR_W-1:0]]);
  end
`endif

  assign baud_done = (baud_cnt == BAUD_LAST);

  // Frame sequencer: every non-idle state lasts exactly CLKS_PER_BIT cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (!empty) state <= S_START;
        end
        S_START: begin
          if (baud_done) begin
            baud_cnt <= '0;
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              bit_cnt <= '0;
`ifdef UART_PARITY_EN
              state   <= S_PARITY;
`else
              state   <= S_STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
`ifdef UART_PARITY_EN
        S_PARITY: begin
          if (baud_done) begin
            baud_cnt <= '0;
            state    <= S_STOP;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
`endif
        S_STOP: begin
          if (baud_done) begin
            baud_cnt <= '0;
            state    <= S_IDLE;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        default: begin
          state    <= S_IDLE;
          baud_cnt <= '0;
          bit_cnt  <= '0;
        end
      endcase
    end
  end

  // ---- stage p2: registered line outputs, one cycle behind the sequencer ----
  // Line driver: level follows the current state, registered for a glitch-free tx.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx <= 1'b1;
    end else begin
      case (state)
        S_START:  tx <= 1'b0;
        S_DATA:   tx <= shreg[bit_cnt];
`ifdef UART_PARITY_EN
        S_PARITY: tx <= par_bit;
`endif
        default:  tx <= 1'b1;
      endcase
    end
  end

  // Busy while a frame is in flight or bytes are still queued.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_busy <= 1'b0;
    end else begin
      tx_busy <= (state != S_IDLE) | ~empty;
    end
  end

  // Zero-wait-state read mux; zero everywhere outside the window.
  always_comb begin
    data_out = 8'h00;
    if (!rw && hit_st) begin
      data_out = {4'b0000, overflow, (state != S_IDLE), full, empty};
    end
  end

endmodule

// File: tb/tb_uart_tx_port.sv
// tb_uart_tx_port: directed bench for uart_tx_port with CLKS_PER_BIT = 4 and
// FIFO_DEPTH = 4. A line monitor decodes frames on tx; directed tests compare
// register reads, tx/tx_busy timing and decoded frames against hand-computed
// values. Define UART_PARITY_EN for both bench and design to check 8E1.
module tb_uart_tx_port;

  localparam int         CPB  = 4;
  localparam logic [8:0] TXD  = 9'h1F0;
  localparam logic [8:0] STS  = 9'h1F1;
`ifdef UART_PARITY_EN
  localparam int         FRAME = 44;
`else
  localparam int         FRAME = 40;
`endif
  localparam int         PERIOD = FRAME + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic [8:0] address;
  logic [7:0] data_in;
  logic       rw;
  logic [7:0] data_out;
  logic       tx;
  logic       tx_busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int fall_cnt = 0;
  logic prev_tx = 1'b1;

  typedef struct {
    logic [7:0] data;
    logic       start_bit;
    logic       par;
    logic       stop_bit;
    int         t;
  } frame_t;

  frame_t mq[$];

  uart_tx_port #(
    .BASE_ADDR   (9'h1F0),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .address (address),
    .data_in (data_in),
    .rw      (rw),
    .data_out(data_out),
    .tx      (tx),
    .tx_busy (tx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (prev_tx === 1'b1 && tx === 1'b0) fall_cnt <= fall_cnt + 1;
    prev_tx <= tx;
  end

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Line monitor: mid-bit sampling on the falling clock edge.
  initial begin : monitor
    frame_t f;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        f.t = cyc;
        repeat (2) @(negedge clk);
        f.start_bit = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          f.data[i] = tx;
        end
        f.par = 1'b0;
`ifdef UART_PARITY_EN
        repeat (CPB) @(negedge clk);
        f.par = tx;
`endif
        repeat (CPB) @(negedge clk);
        f.stop_bit = tx;
        mq.push_back(f);
      end
    end
  end

  task automatic wr_reg(input logic [8:0] a, input logic [7:0] d);
    @(negedge clk);
    address = a;
    data_in = d;
    rw = 1'b1;
    @(negedge clk);
    rw = 1'b0;
    address = 9'h000;
  endtask

  task automatic rd_reg(input logic [8:0] a, output logic [7:0] v);
    @(negedge clk);
    address = a;
    rw = 1'b0;
    #1;
    v = data_out;
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    int n;
    n = 0;
    while (tx_busy !== 1'b0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk_val(tag, (n >= max_cyc), 0);
  endtask

  task automatic chk_frame(input string tag, input logic [7:0] exp, output int t);
    frame_t f;
    t = 0;
    if (mq.size() == 0) begin
      chk_val({tag, "_missing"}, 0, 1);
    end else begin
      f = mq.pop_front();
      t = f.t;
      chk_val({tag, "_data"}, f.data, exp);
      chk_val({tag, "_start"}, f.start_bit, 0);
      chk_val({tag, "_stop"}, f.stop_bit, 1);
`ifdef UART_PARITY_EN
      chk_val({tag, "_par"}, f.par, ^exp);
`endif
    end
  endtask

  initial begin : main
    logic [7:0] v;
    int t;
    int tprev;
    int fall0;
    logic [7:0] bytes4 [6];
    bytes4[0] = 8'h11; bytes4[1] = 8'h22; bytes4[2] = 8'h33;
    bytes4[3] = 8'h44; bytes4[4] = 8'h55; bytes4[5] = 8'h66;

    reset = 1'b1;
    rw = 1'b0;
    address = 9'h000;
    data_in = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // 1. reset state
    rd_reg(STS, v);
    chk_val("t1_status", v, 8'h01);
    chk_val("t1_tx", tx, 1);
    chk_val("t1_busy", tx_busy, 0);
    rd_reg(9'h000, v);
    chk_val("t1_rd_outside", v, 8'h00);
    rd_reg(TXD, v);
    chk_val("t1_rd_txdata", v, 8'h00);
    rd_reg(9'h1F2, v);
    chk_val("t1_rd_past_window", v, 8'h00);

    // 2. single byte 8'hA5: latency, bit timing, busy drop
    mq.delete();
    wr_reg(TXD, 8'hA5);
    @(negedge clk);
    chk_val("t2_tx_before_start", tx, 1);
    chk_val("t2_busy_after_pop", tx_busy, 1);
    @(negedge clk);
    chk_val("t2_tx_start", tx, 0);
    repeat (3) @(negedge clk);
    chk_val("t2_tx_start_end", tx, 0);
    @(negedge clk);
    chk_val("t2_tx_bit0", tx, 1);
    repeat (FRAME - 5) @(negedge clk);
    chk_val("t2_busy_last", tx_busy, 1);
    chk_val("t2_tx_stop", tx, 1);
    @(negedge clk);
    chk_val("t2_busy_drop", tx_busy, 0);
    chk_val("t2_nframes", mq.size(), 1);
    chk_frame("t2", 8'hA5, t);

    // 3. held write pushes exactly once
    mq.delete();
    @(negedge clk);
    address = TXD;
    data_in = 8'h3C;
    rw = 1'b1;
    #1;
    chk_val("t3_rd_during_wr", data_out, 8'h00);
    repeat (10) @(negedge clk);
    rw = 1'b0;
    address = 9'h000;
    rd_reg(STS, v);
    chk_val("t3_status", v, 8'h05);
    wait_idle("t3_timeout", 200);
    repeat (5) @(negedge clk);
    chk_val("t3_nframes", mq.size(), 1);
    chk_frame("t3", 8'h3C, t);

    // 4. overflow, clear, five frames with 1-clk gaps
    mq.delete();
    for (int i = 0; i < 6; i++) wr_reg(TXD, bytes4[i]);
    rd_reg(STS, v);
    chk_val("t4_status_ovf", v, 8'h0E);
    wr_reg(STS, 8'hFF);
    rd_reg(STS, v);
    chk_val("t4_status_clr", v, 8'h06);
    wait_idle("t4_timeout", 600);
    repeat (5) @(negedge clk);
    chk_val("t4_nframes", mq.size(), 5);
    tprev = 0;
    for (int i = 0; i < 5; i++) begin
      chk_frame($sformatf("t4_f%0d", i), bytes4[i], t);
      if (i > 0) chk_val($sformatf("t4_gap%0d", i), t - tprev, PERIOD);
      tprev = t;
    end
    rd_reg(STS, v);
    chk_val("t4_status_end", v, 8'h01);

    // 5. reset during data bit 3 aborts and flushes
    wr_reg(TXD, 8'hF0);
    wr_reg(TXD, 8'h0F);
    wr_reg(TXD, 8'h5A);
    repeat (14) @(negedge clk);
    chk_val("t5_mid_bit3", tx, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_val("t5_tx_after_rst", tx, 1);
    chk_val("t5_busy_after_rst", tx_busy, 0);
    rd_reg(STS, v);
    chk_val("t5_status", v, 8'h01);
    fall0 = fall_cnt;
    repeat (200) @(negedge clk);
    chk_val("t5_no_frame", fall_cnt - fall0, 0);
    rd_reg(STS, v);
    chk_val("t5_status_end", v, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
